// File: rtl/id_hazard_stage.sv
// ID stage with hazard detection: decodes the instruction in IF/ID, reads the
// register file with write-through from WB, detects load-use and branch hazards,
// resolves branches in ID and loads the ID/EX pipeline register.
module id_hazard_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [0:31]       if_inst,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_wren,
  input  logic              ex_memrd,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic              mem_wren,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_wren,
  input  logic [DATA_W-1:0] wb_data,
  output logic              if_stall,
  output logic              if_flush,
  output logic [15:0]       br_target,
  output logic              idex_valid,
  output logic              idex_wren,
  output logic              idex_memen,
  output logic              idex_memwren,
  output logic [ADDR_W-1:0] idex_rd,
  output logic [5:0]        idex_opcode,
  output logic [DATA_W-1:0] idex_ra_data,
  output logic [DATA_W-1:0] idex_rb_data,
  output logic [1:0]        idex_fwd_a,
  output logic [1:0]        idex_fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned NREG = 2**ADDR_W;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b101010,
    OP_LOAD  = 6'b100000,
    OP_STORE = 6'b100001,
    OP_BEZ   = 6'b100010,
    OP_BNEZ  = 6'b100011,
    OP_NOP   = 6'b111100
  } opcode_e;

  function automatic logic f_match(input logic [ADDR_W-1:0] src,
                                   input logic [ADDR_W-1:0] dst,
                                   input logic              wren);
    return wren && (dst != '0) && (dst == src);
  endfunction

  function automatic logic [1:0] f_fwd(input logic ex_hit, input logic mem_hit);
    return ex_hit ? 2'b01 : (mem_hit ? 2'b10 : 2'b00);
  endfunction

  logic [DATA_W-1:0] r_rf [NREG];

  logic              r_valid, r_wren, r_memen, r_memwren;
  logic [ADDR_W-1:0] r_rd;
  logic [5:0]        r_opcode;
  logic [DATA_W-1:0] r_ra_data, r_rb_data;
  logic [1:0]        r_fwd_a, r_fwd_b;
  logic [CNT_W-1:0]  r_cnt;

  logic [5:0]        w_op;
  logic [ADDR_W-1:0] w_rd, w_ra, w_rb, w_srcb;
  logic [15:0]       w_imm;
  logic              w_is_rtype, w_is_load, w_is_store, w_is_bez, w_is_bnez, w_is_branch;
  logic              w_reads_a, w_reads_b;
  logic              w_ex_a, w_ex_b, w_mem_a, w_mem_b;
  logic              w_load_use, w_br_hazard, w_hazard, w_taken, w_issue;
  logic [DATA_W-1:0] w_ra_val, w_rb_val;

  assign w_op   = if_inst[0:5];
  assign w_rd   = ADDR_W'(if_inst[6:10]);
  assign w_ra   = ADDR_W'(if_inst[11:15]);
  assign w_rb   = ADDR_W'(if_inst[16:20]);
  assign w_imm  = if_inst[16:31];

  assign w_is_rtype  = (w_op == OP_RTYPE);
  assign w_is_load   = (w_op == OP_LOAD);
  assign w_is_store  = (w_op == OP_STORE);
  assign w_is_bez    = (w_op == OP_BEZ);
  assign w_is_bnez   = (w_op == OP_BNEZ);
  assign w_is_branch = w_is_bez || w_is_bnez;

  // Operand B carries rD for stores (store data) and branches (test value).
  assign w_srcb    = (w_is_store || w_is_branch) ? w_rd : w_rb;
  assign w_reads_a = w_is_rtype || w_is_load || w_is_store;
  assign w_reads_b = w_is_rtype || w_is_store || w_is_branch;

  assign w_ex_a  = w_reads_a && f_match(w_ra,   ex_rd,  ex_wren);
  assign w_ex_b  = w_reads_b && f_match(w_srcb, ex_rd,  ex_wren);
  assign w_mem_a = w_reads_a && f_match(w_ra,   mem_rd, mem_wren);
  assign w_mem_b = w_reads_b && f_match(w_srcb, mem_rd, mem_wren);

  assign w_load_use  = if_valid && ex_memrd && (w_ex_a || w_ex_b);
  assign w_br_hazard = if_valid && w_is_branch && (w_ex_b || w_mem_b);
  assign w_hazard    = w_load_use || w_br_hazard;

  // Register reads: r0 is hardwired zero, same-cycle WB write bypasses the array.
  assign w_ra_val = (w_ra == '0) ? '0 :
                    (wb_wren && (wb_rd == w_ra)) ? wb_data : r_rf[w_ra];
  assign w_rb_val = (w_srcb == '0) ? '0 :
                    (wb_wren && (wb_rd == w_srcb)) ? wb_data : r_rf[w_srcb];

  assign w_taken = w_is_bez ? (w_rb_val == '0) : (w_rb_val != '0);
  assign w_issue = if_valid && !w_hazard && (w_is_rtype || w_is_load || w_is_store);

  assign if_stall  = !reset && w_hazard;
  assign if_flush  = !reset && if_valid && w_is_branch && !w_hazard && w_taken;
  assign br_target = reset ? '0 : w_imm;

  // Register file write port; entry 0 is never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) r_rf[ADDR_W'(i)] <= '0;
    end else if (wb_wren && (wb_rd != '0)) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  // ID/EX register: issue decoded instruction or load a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || !w_issue) begin
      r_valid   <= 1'b0;
      r_wren    <= 1'b0;
      r_memen   <= 1'b0;
      r_memwren <= 1'b0;
      r_rd      <= '0;
      r_opcode  <= '0;
      r_ra_data <= '0;
      r_rb_data <= '0;
      r_fwd_a   <= '0;
      r_fwd_b   <= '0;
    end else begin
      r_valid   <= 1'b1;
      r_wren    <= w_is_rtype || w_is_load;
      r_memen   <= w_is_load || w_is_store;
      r_memwren <= w_is_store;
      r_rd      <= (w_is_rtype || w_is_load) ? w_rd : '0;
      r_opcode  <= w_op;
      r_ra_data <= w_ra_val;
      r_rb_data <= w_rb_val;
      r_fwd_a   <= f_fwd(w_ex_a, w_mem_a);
      r_fwd_b   <= f_fwd(w_ex_b, w_mem_b);
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_hazard && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign idex_valid   = r_valid;
  assign idex_wren    = r_wren;
  assign idex_memen   = r_memen;
  assign idex_memwren = r_memwren;
  assign idex_rd      = r_rd;
  assign idex_opcode  = r_opcode;
  assign idex_ra_data = r_ra_data;
  assign idex_rb_data = r_rb_data;
  assign idex_fwd_a   = r_fwd_a;
  assign idex_fwd_b   = r_fwd_b;
  assign stall_cnt    = r_cnt;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Directed-vector bench for id_hazard_stage with hand-computed expectations.
module tb_id_hazard_stage;

  localparam logic [5:0] RT   = 6'b101010;
  localparam logic [5:0] LD   = 6'b100000;
  localparam logic [5:0] ST   = 6'b100001;
  localparam logic [5:0] BEZ  = 6'b100010;
  localparam logic [5:0] BNEZ = 6'b100011;
  localparam logic [5:0] NOP  = 6'b111100;

  logic        clk, reset, if_valid;
  logic [31:0] if_inst;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_wren, ex_memrd, mem_wren, wb_wren;
  logic [63:0] wb_data;
  logic        if_stall, if_flush;
  logic [15:0] br_target;
  logic        idex_valid, idex_wren, idex_memen, idex_memwren;
  logic [4:0]  idex_rd;
  logic [5:0]  idex_opcode;
  logic [63:0] idex_ra_data, idex_rb_data;
  logic [1:0]  idex_fwd_a, idex_fwd_b;
  logic [3:0]  stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  id_hazard_stage #(.DATA_W(64), .ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst),
    .ex_rd(ex_rd), .ex_wren(ex_wren), .ex_memrd(ex_memrd),
    .mem_rd(mem_rd), .mem_wren(mem_wren),
    .wb_rd(wb_rd), .wb_wren(wb_wren), .wb_data(wb_data),
    .if_stall(if_stall), .if_flush(if_flush), .br_target(br_target),
    .idex_valid(idex_valid), .idex_wren(idex_wren), .idex_memen(idex_memen),
    .idex_memwren(idex_memwren), .idex_rd(idex_rd), .idex_opcode(idex_opcode),
    .idex_ra_data(idex_ra_data), .idex_rb_data(idex_rb_data),
    .idex_fwd_a(idex_fwd_a), .idex_fwd_b(idex_fwd_b), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic [4:0]  exrd;  logic exw; logic exm;
    logic [4:0]  mrd;   logic mw;
    logic [4:0]  wrd;   logic ww;  logic [63:0] wd;
    logic        e_st, e_fl, e_val, e_wr, e_me, e_mwr;
    logic [4:0]  e_rd;
    logic [1:0]  e_fa, e_fb;
    logic [63:0] e_ra, e_rb;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ins_r(int rd, int ra, int rb);
    return {RT, 5'(rd), 5'(ra), 5'(rb), 11'b0};
  endfunction

  function automatic logic [31:0] ins_i(logic [5:0] op, int rd, int ra, int imm);
    return {op, 5'(rd), 5'(ra), 16'(imm)};
  endfunction

  function automatic vec_t mk(int v, logic [31:0] inst, int exrd, int exw, int exm,
                              int mrd, int mw, int wrd, int ww, logic [63:0] wd,
                              int st, int fl, int val, int wr, int me, int mwr, int rd,
                              int fa, int fb, logic [63:0] ra, logic [63:0] rb, int cnt);
    vec_t t;
    t.v = 1'(v); t.inst = inst;
    t.exrd = 5'(exrd); t.exw = 1'(exw); t.exm = 1'(exm);
    t.mrd = 5'(mrd); t.mw = 1'(mw);
    t.wrd = 5'(wrd); t.ww = 1'(ww); t.wd = wd;
    t.e_st = 1'(st); t.e_fl = 1'(fl); t.e_val = 1'(val); t.e_wr = 1'(wr);
    t.e_me = 1'(me); t.e_mwr = 1'(mwr); t.e_rd = 5'(rd);
    t.e_fa = 2'(fa); t.e_fb = 2'(fb); t.e_ra = ra; t.e_rb = rb; t.e_cnt = 4'(cnt);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    if_valid = t.v;   if_inst = t.inst;
    ex_rd = t.exrd;   ex_wren = t.exw;  ex_memrd = t.exm;
    mem_rd = t.mrd;   mem_wren = t.mw;
    wb_rd = t.wrd;    wb_wren = t.ww;   wb_data = t.wd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},  64'(if_stall), 64'(0));
    chk({tag, "_flush"},  64'(if_flush), 64'(0));
    chk({tag, "_brtgt"},  64'(br_target), 64'(0));
    chk({tag, "_valid"},  64'(idex_valid), 64'(0));
    chk({tag, "_wren"},   64'(idex_wren), 64'(0));
    chk({tag, "_memen"},  64'(idex_memen), 64'(0));
    chk({tag, "_memwr"},  64'(idex_memwren), 64'(0));
    chk({tag, "_rd"},     64'(idex_rd), 64'(0));
    chk({tag, "_op"},     64'(idex_opcode), 64'(0));
    chk({tag, "_ra"},     idex_ra_data, 64'(0));
    chk({tag, "_rb"},     idex_rb_data, 64'(0));
    chk({tag, "_fwda"},   64'(idex_fwd_a), 64'(0));
    chk({tag, "_fwdb"},   64'(idex_fwd_b), 64'(0));
    chk({tag, "_cnt"},    64'(stall_cnt), 64'(0));
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    logic [31:0] w;
    string tag;
    tag = $sformatf("v%0d", idx);
    w = t.inst;
    drive(t);
    #1;
    chk({tag, "_stall"}, 64'(if_stall), 64'(t.e_st));
    chk({tag, "_flush"}, 64'(if_flush), 64'(t.e_fl));
    chk({tag, "_brtgt"}, 64'(br_target), 64'(w[15:0]));
    @(posedge clk); #1;
    chk({tag, "_valid"}, 64'(idex_valid), 64'(t.e_val));
    chk({tag, "_wren"},  64'(idex_wren), 64'(t.e_wr));
    chk({tag, "_memen"}, 64'(idex_memen), 64'(t.e_me));
    chk({tag, "_memwr"}, 64'(idex_memwren), 64'(t.e_mwr));
    chk({tag, "_rd"},    64'(idex_rd), 64'(t.e_rd));
    chk({tag, "_op"},    64'(idex_opcode), t.e_val ? 64'(w[31:26]) : 64'(0));
    chk({tag, "_fwda"},  64'(idex_fwd_a), 64'(t.e_fa));
    chk({tag, "_fwdb"},  64'(idex_fwd_b), 64'(t.e_fb));
    chk({tag, "_ra"},    idex_ra_data, t.e_ra);
    chk({tag, "_rb"},    idex_rb_data, t.e_rb);
    chk({tag, "_cnt"},   64'(stall_cnt), 64'(t.e_cnt));
  endtask

  initial begin
    vec_t s;
    logic [3:0] exp_cnt;

    //        v  inst                      exrd w m mrd w wrd w data     st fl va wr me mw rd fa fb ra      rb      cnt
    vecs.push_back(mk(1, ins_r(1,3,0),           0,0,0, 0,0, 3,1,64'h55,  0,0, 1,1,0,0, 1, 0,0, 64'h55, 64'h0,  0));
    vecs.push_back(mk(1, ins_r(5,3,3),           0,0,0, 0,0, 0,0,64'h0,   0,0, 1,1,0,0, 5, 0,0, 64'h55, 64'h55, 0));
    vecs.push_back(mk(1, ins_r(6,4,0),           4,1,1, 0,0, 0,0,64'h0,   1,0, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  1));
    vecs.push_back(mk(1, ins_r(6,4,0),           0,0,0, 0,0, 0,0,64'h0,   0,0, 1,1,0,0, 6, 0,0, 64'h0,  64'h0,  1));
    vecs.push_back(mk(1, ins_r(7,2,2),           2,1,0, 2,1, 0,0,64'h0,   0,0, 1,1,0,0, 7, 1,1, 64'h0,  64'h0,  1));
    vecs.push_back(mk(1, ins_r(7,2,3),           0,1,0, 0,1, 0,0,64'h0,   0,0, 1,1,0,0, 7, 0,0, 64'h0,  64'h55, 1));
    vecs.push_back(mk(1, ins_r(7,2,3),           9,1,0, 2,1, 0,0,64'h0,   0,0, 1,1,0,0, 7, 2,0, 64'h0,  64'h55, 1));
    vecs.push_back(mk(1, ins_i(BEZ,0,0,'h1234),  0,0,0, 0,0, 0,0,64'h0,   0,1, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  1));
    vecs.push_back(mk(1, ins_i(BNEZ,0,0,'h00ff), 0,0,0, 0,0, 0,0,64'h0,   0,0, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  1));
    vecs.push_back(mk(1, ins_i(LD,8,3,4),        0,0,0, 0,0, 0,0,64'h0,   0,0, 1,1,1,0, 8, 0,0, 64'h55, 64'h0,  1));
    vecs.push_back(mk(1, ins_i(ST,3,3,0),        0,0,0, 0,0, 0,0,64'h0,   0,0, 1,0,1,1, 0, 0,0, 64'h55, 64'h55, 1));
    vecs.push_back(mk(0, ins_r(6,4,0),           4,1,1, 0,0, 0,0,64'h0,   0,0, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  1));
    vecs.push_back(mk(1, ins_i(NOP,1,3,0),       0,0,0, 0,0, 0,0,64'h0,   0,0, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  1));
    vecs.push_back(mk(1, ins_i(6'b000000,1,3,0), 0,0,0, 0,0, 0,0,64'h0,   0,0, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  1));
    vecs.push_back(mk(1, ins_i(BNEZ,7,0,'h0abc), 0,0,0, 7,1, 0,0,64'h0,   1,0, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  2));
    vecs.push_back(mk(1, ins_i(BNEZ,7,0,'h0abc), 0,0,0, 0,0, 7,1,64'h1,   0,1, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  2));
    vecs.push_back(mk(1, ins_i(BEZ,7,0,'h0011),  0,0,0, 0,0, 0,0,64'h0,   0,0, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  2));
    vecs.push_back(mk(1, ins_i(BEZ,7,0,'h0011),  7,1,0, 0,0, 0,0,64'h0,   1,0, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  3));
    vecs.push_back(mk(1, ins_i(BEZ,9,0,'h0042),  9,1,1, 0,0, 0,0,64'h0,   1,0, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  4));
    vecs.push_back(mk(1, ins_i(BEZ,9,0,'h0042),  0,0,0, 0,0, 0,0,64'h0,   0,1, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  4));
    vecs.push_back(mk(1, ins_r(1,0,0),           0,0,0, 0,0, 0,1,64'hff,  0,0, 1,1,0,0, 1, 0,0, 64'h0,  64'h0,  4));
    vecs.push_back(mk(1, ins_r(1,0,0),           0,0,0, 0,0, 0,0,64'h0,   0,0, 1,1,0,0, 1, 0,0, 64'h0,  64'h0,  4));
    vecs.push_back(mk(1, ins_i(ST,5,0,0),        5,1,1, 0,0, 0,0,64'h0,   1,0, 0,0,0,0, 0, 0,0, 64'h0,  64'h0,  5));

    // Reset held with hazard-causing inputs: stall must be masked.
    reset = 1'b1;
    drive(vecs[2]);
    #12;
    chk_all_zero("rst");
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Long stall run: counter must saturate rather than wrap.
    s = vecs[vecs.size()-1];
    exp_cnt = 4'd5;
    for (int k = 0; k < 19; k++) begin
      drive(s);
      @(posedge clk); #1;
      exp_cnt = (exp_cnt == 4'hf) ? 4'hf : exp_cnt + 4'd1;
      chk($sformatf("sat%0d_cnt", k), 64'(stall_cnt), 64'(exp_cnt));
    end
    chk("sat_final", 64'(stall_cnt), 64'hf);
    chk("sat_stall", 64'(if_stall), 64'(1));

    // Reset mid-stall: state clears without a clock edge.
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_stall");
    @(posedge clk); #1;
    reset = 1'b0;

    // First edge after reset: RF cleared (r3 reads 0), instruction issues normally.
    drive(mk(1, ins_r(2,3,7), 0,0,0, 0,0, 0,0,64'h0, 0,0,0,0,0,0,0,0,0,64'h0,64'h0,0));
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(idex_valid), 64'(1));
    chk("post_rst_rd",    64'(idex_rd), 64'(2));
    chk("post_rst_ra",    idex_ra_data, 64'(0));
    chk("post_rst_rb",    idex_rb_data, 64'(0));

    // Reset mid-branch with a loaded ID/EX register.
    drive(mk(1, ins_r(4,0,0), 0,0,0, 0,0, 6,1,64'h99, 0,0,0,0,0,0,0,0,0,64'h0,64'h0,0));
    @(posedge clk); #1;
    drive(mk(1, ins_r(4,6,0), 0,0,0, 0,0, 0,0,64'h0, 0,0,0,0,0,0,0,0,0,64'h0,64'h0,0));
    @(posedge clk); #1;
    chk("pre_br_ra", idex_ra_data, 64'h99);
    drive(mk(1, ins_i(BEZ,0,0,'h0777), 0,0,0, 0,0, 0,0,64'h0, 0,0,0,0,0,0,0,0,0,64'h0,64'h0,0));
    #1 chk("pre_br_flush", 64'(if_flush), 64'(1));
    #1 reset = 1'b1;
    #1 chk_all_zero("rst_branch");
    @(posedge clk); #1;
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/id_hazard_stage.md
ID_HAZARD_STAGE -- requirements
Module: id_hazard_stage

Interface
REQ-001 Parameter DATA_W, default 64, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width; register count is 2**ADDR_W.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 if_valid  in  1  if_inst holds a valid instruction.
REQ-007 if_inst  in  32  instruction word: opcode [0:5], rD [6:10], rA [11:15], rB [16:20], imm [16:31].
REQ-008 ex_rd / ex_wren / ex_memrd  in  ADDR_W/1/1  destination, write enable and load flag of the instruction in EX.
REQ-009 mem_rd / mem_wren  in  ADDR_W/1  destination and write enable of the instruction in MEM.
REQ-010 wb_rd / wb_wren / wb_data  in  ADDR_W/1/DATA_W  register-file write port.
REQ-011 if_stall  out  1  IF and the IF/ID register hold.
REQ-012 if_flush  out  1  taken branch; IF squashes and loads br_target.
REQ-013 br_target  out  16  branch target, equal to imm.
REQ-014 idex_valid, idex_wren, idex_memen, idex_memwren  out  1 each  registered ID/EX control.
REQ-015 idex_rd  out  ADDR_W; idex_opcode  out  6  registered ID/EX fields.
REQ-016 idex_ra_data, idex_rb_data  out  DATA_W  registered operands.
REQ-017 idex_fwd_a, idex_fwd_b  out  2  registered forward selects: 00 RF, 01 EX/MEM, 10 MEM/WB.
REQ-018 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-019 Decode: 101010 R-type (reads rA, rB; writes rD); 100000 load (reads rA; writes rD; memen); 100001 store (reads rA, rD; memen, memwren); 100010 BEZ and 100011 BNEZ (read rD); 111100 NOP; every other opcode is treated as NOP.
REQ-020 Internal register file: 2**ADDR_W x DATA_W. Register 0 reads 0 and ignores writes. A WB write and a read of the same nonzero register in one cycle return wb_data (write-through).
REQ-021 Source match: EX or MEM destination is nonzero, its write enable is 1, and it equals a register the decoded instruction reads.
REQ-022 Load-use hazard: if_valid, ex_memrd, and an EX source match.
REQ-023 Branch hazard: if_valid, branch opcode, and an EX or MEM source match on rD.
REQ-024 If either hazard holds: if_stall=1, if_flush=0, and a bubble is loaded into ID/EX (all idex control 0, idex_valid=0); stall_cnt increments, saturating at all-ones.
REQ-025 Branch with no hazard: resolved in ID from the RF or bypassed operand.
  - BEZ taken when the operand is 0; BNEZ taken when it is nonzero.
  - When taken, if_flush=1 for that cycle and br_target=imm.
  - Branches always load a bubble into ID/EX.
REQ-026 Non-branch valid instruction with no hazard loads ID/EX on the next edge with decoded control, operands and forward selects; latency 1 cycle. idex_valid=1 except for NOP.
REQ-027 Forward select per operand: 01 if EX source match; else 10 if MEM source match; else 00. EX has priority over MEM.
REQ-028 if_valid=0: bubble in ID/EX, if_stall=0, if_flush=0, stall_cnt unchanged.
REQ-029 A stall and a taken branch in the same cycle: the stall wins and the branch is re-evaluated in the next cycle.
REQ-030 if_stall, if_flush and br_target are combinational from the current inputs and state.

Reset
REQ-031 While reset=1:
  - all idex outputs, stall_cnt and every RF entry are 0;
  - if_stall and if_flush are forced to 0.
REQ-032 Reset asserted mid-stall or mid-branch clears state immediately, with no clock edge required. The first edge after deassertion processes the current if_inst normally.

Verification
REQ-033 Write r3=0x55 via WB with a same-cycle R-type read of r3 -> idex_ra_data=0x55 on the next edge; fwd_a=00.
REQ-034 ex_memrd=1, ex_rd=4, ex_wren=1; ID R-type reads rA=4 -> if_stall=1, bubble in ID/EX, stall_cnt 0->1. Next cycle with EX cleared -> instruction issues with idex_valid=1.
REQ-035 BEZ on r0 with no hazards -> if_flush=1, br_target=imm, idex_valid=0; BNEZ on r0 -> if_flush=0.
REQ-036 BNEZ reads r7 with mem_rd=7, mem_wren=1 -> if_stall=1, if_flush=0. Next cycle with WB writing r7=1 and MEM clear -> if_flush=1.
REQ-037 ex_rd=mem_rd=2, both write enabled; R-type reads rA=rB=2 -> idex_fwd_a=idex_fwd_b=01. With rd=0 in both stages -> 00.
REQ-038 Force 2**CNT_W+3 stall cycles -> stall_cnt saturates at all-ones. Assert reset mid-stall -> all outputs 0 before the next clock edge.
